// File: rtl/prod_acc_pkg.sv
// Shared types and default widths for the product accumulator block.
package prod_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  localparam int PROD_W_DEF    = 8;
  localparam int ACC_W_DEF     = 12;
  localparam int BLOCK_LEN_DEF = 4;

endpackage

// File: rtl/sat_adder.sv
// Unsigned saturating adder: acc + zero-extended operand, clamped to ACC_W bits.
module sat_adder #(
  parameter int ACC_W = 12,
  parameter int OP_W  = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [OP_W-1:0]  operand_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  localparam int PAD_W = ACC_W + 1 - OP_W;

  logic [ACC_W:0] sum_wide;

  // One guard bit is enough: the carry out of the ACC_W-bit add marks saturation.
  assign sum_wide = {1'b0, acc_i} + {{PAD_W{1'b0}}, operand_i};
  assign ovf_o    = sum_wide[ACC_W];
  assign sum_o    = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of BLOCK_LEN multiplier products into a saturating accumulator
// and presents each block sum through a valid/ready handshake.
//
// state | meaning
// ACCUM | accepting products, partial sum visible on acc_out
// HOLD  | block complete, result presented until consumed
module product_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF,
  localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [ACC_W-1:0] sum_d;
  logic             sat_d;
  logic             last_d;

  sat_adder #(
    .ACC_W (ACC_W),
    .OP_W  (PROD_W)
  ) u_sat_adder (
    .acc_i     (acc_q),
    .operand_i (product),
    .sum_o     (sum_d),
    .ovf_o     (sat_d)
  );

  assign last_d = (cnt_q == CNT_W'(BLOCK_LEN - 1));

  // clear outranks both the input accept and the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q <= sum_d;
            ovf_q <= ovf_q | sat_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_d) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed bench for product_accumulator against a sum/count model.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear, in_valid, out_ready;
  logic [7:0]  product;
  logic        in_ready, out_valid, overflow;
  logic [11:0] acc_out;
  logic [2:0]  count;

  logic        s_clear, s_in_valid, s_out_ready;
  logic [7:0]  s_product;
  logic        s_in_ready, s_out_valid, s_overflow;
  logic [11:0] s_acc_out;
  logic [5:0]  s_count;

  int checks   = 0;
  int failures = 0;

  // reference model of the default instance: true block sum clamped at 4095
  int m_acc, m_cnt;
  bit m_ovf, m_hold;

  product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .product(product), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .overflow(overflow), .count(count)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(12), .BLOCK_LEN(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .product(s_product), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .acc_out(s_acc_out), .overflow(s_overflow), .count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_zero();
    m_acc = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
  endtask

  // apply one cycle of stimulus to the default instance, advance the model, settle
  task automatic drive(input bit v, input int p, input bit r, input bit c);
    int tot;
    in_valid = v; product = 8'(p); out_ready = r; clear = c;
    @(posedge clk);
    if (c) model_zero();
    else if (!m_hold) begin
      if (v) begin
        tot = m_acc + (p & 255);
        if (tot > 4095) begin m_acc = 4095; m_ovf = 1; end
        else m_acc = tot;
        m_cnt++;
        if (m_cnt == 4) m_hold = 1;
      end
    end else if (r) model_zero();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clear = 0; in_valid = 0; out_ready = 0; product = 0;
    s_clear = 0; s_in_valid = 0; s_out_ready = 0; s_product = 0;
    model_zero();
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (acc_out !== 12'd0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", acc_out); end
    #1 rst_n = 1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (count !== 3'd0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_cnt_ovf got=%0d/%0b exp=0/0", count, overflow); end
  endtask

  task automatic test_basic();
    int prods[4] = '{15, 30, 225, 100};
    for (int i = 0; i < 4; i++) begin
      drive(1, prods[i], 1, 0);
      checks++; if (acc_out !== m_acc[11:0] || count !== m_cnt[2:0]) begin failures++; $display("FAIL basic_step%0d got=%0d/%0d exp=%0d/%0d", i, acc_out, count, m_acc, m_cnt); end
    end
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL basic_hold got=v%0b r%0b exp=v1 r0", out_valid, in_ready); end
    checks++; if (acc_out !== 12'd370 || count !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL basic_result got=%0d/%0d/%0b exp=370/4/0", acc_out, count, overflow); end
    drive(1, 77, 1, 0);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 12'd0 || count !== 3'd0) begin failures++; $display("FAIL basic_handoff got=r%0b v%0b acc=%0d cnt=%0d exp=r1 v0 acc=0 cnt=0", in_ready, out_valid, acc_out, count); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) drive(1, 225, 0, 0);
    checks++; if (out_valid !== 1'b1 || acc_out !== 12'd900) begin failures++; $display("FAIL bp_result got=v%0b acc=%0d exp=v1 acc=900", out_valid, acc_out); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 7, 0, 0);
      checks++; if (in_ready !== 1'b0 || acc_out !== 12'd900 || count !== 3'd4) begin failures++; $display("FAIL bp_stall%0d got=r%0b acc=%0d cnt=%0d exp=r0 acc=900 cnt=4", i, in_ready, acc_out, count); end
    end
    drive(1, 7, 1, 0);
    checks++; if (in_ready !== 1'b1 || acc_out !== 12'd0 || count !== 3'd0) begin failures++; $display("FAIL bp_handoff got=r%0b acc=%0d cnt=%0d exp=r1 acc=0 cnt=0", in_ready, acc_out, count); end
    drive(1, 7, 1, 0);
    checks++; if (acc_out !== 12'd7 || count !== 3'd1) begin failures++; $display("FAIL bp_first_accept got=%0d/%0d exp=7/1", acc_out, count); end
    for (int i = 0; i < 4; i++) drive(1, $urandom_range(255), 1, 0);
    checks++; if (acc_out !== m_acc[11:0] || out_valid !== m_hold) begin failures++; $display("FAIL bp_drain got=%0d/%0b exp=%0d/%0b", acc_out, out_valid, m_acc, m_hold); end
  endtask

  task automatic test_gapped();
    bit vld[7]     = '{1, 0, 0, 1, 0, 1, 1};
    int val[7]     = '{1, 0, 0, 2, 0, 3, 4};
    int exp_cnt[7] = '{1, 1, 1, 2, 2, 3, 4};
    drive(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      drive(vld[i], vld[i] ? val[i] : int'($urandom_range(255)), 1, 0);
      checks++; if (count !== exp_cnt[i][2:0]) begin failures++; $display("FAIL gapped_count%0d got=%0d exp=%0d", i, count, exp_cnt[i]); end
    end
    checks++; if (out_valid !== 1'b1 || acc_out !== 12'd10) begin failures++; $display("FAIL gapped_result got=v%0b acc=%0d exp=v1 acc=10", out_valid, acc_out); end
    drive(0, 0, 1, 0);
  endtask

  task automatic test_clear();
    drive(1, 20, 1, 0);
    drive(1, 40, 1, 0);
    drive(1, 50, 1, 1);
    checks++; if (acc_out !== 12'd0 || count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL clear_accum got=acc%0d cnt%0d v%0b r%0b exp=acc0 cnt0 v0 r1", acc_out, count, out_valid, in_ready); end
    for (int i = 0; i < 4; i++) drive(1, 200, 0, 0);
    checks++; if (out_valid !== 1'b1 || acc_out !== 12'd800) begin failures++; $display("FAIL clear_prehold got=v%0b acc=%0d exp=v1 acc=800", out_valid, acc_out); end
    drive(0, 0, 0, 1);
    checks++; if (acc_out !== 12'd0 || count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL clear_hold got=acc%0d cnt%0d v%0b r%0b exp=acc0 cnt0 v0 r1", acc_out, count, out_valid, in_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3) != 0), $urandom_range(255), ($urandom_range(2) != 0), ($urandom_range(40) == 0));
      checks++;
      if (acc_out !== m_acc[11:0] || count !== m_cnt[2:0] || overflow !== m_ovf ||
          out_valid !== m_hold || in_ready !== !m_hold) begin
        failures++;
        $display("FAIL random_cyc%0d got=acc%0d cnt%0d ovf%0b v%0b r%0b exp=acc%0d cnt%0d ovf%0b v%0b r%0b",
                 i, acc_out, count, overflow, out_valid, in_ready, m_acc, m_cnt, m_ovf, m_hold, !m_hold);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_acc;
    in_valid = 0; out_ready = 0; clear = 0;
    s_clear = 0; s_out_ready = 0; s_in_valid = 1; s_product = 8'd225;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      exp_acc = (225 * k > 4095) ? 4095 : 225 * k;
      checks++;
      if (s_acc_out !== exp_acc[11:0] || s_overflow !== (225 * k > 4095) || s_count !== k[5:0]) begin
        failures++;
        $display("FAIL sat_step%0d got=acc%0d ovf%0b cnt%0d exp=acc%0d ovf%0b cnt%0d", k, s_acc_out, s_overflow, s_count, exp_acc, (225 * k > 4095), k);
      end
    end
    checks++; if (s_out_valid !== 1'b1 || s_acc_out !== 12'd4095 || s_overflow !== 1'b1) begin failures++; $display("FAIL sat_result got=v%0b acc=%0d ovf=%0b exp=v1 acc=4095 ovf=1", s_out_valid, s_acc_out, s_overflow); end
    s_in_valid = 0; s_out_ready = 1;
    @(posedge clk); #1;
    checks++; if (s_overflow !== 1'b0 || s_acc_out !== 12'd0 || s_count !== 6'd0 || s_in_ready !== 1'b1) begin failures++; $display("FAIL sat_handoff got=ovf%0b acc%0d cnt%0d r%0b exp=ovf0 acc0 cnt0 r1", s_overflow, s_acc_out, s_count, s_in_ready); end
    s_out_ready = 0;
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 150, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_prehold got=v%0b exp=v1", out_valid); end
    s_in_valid = 1; s_product = 8'd99;
    @(posedge clk); #1;
    s_in_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || acc_out !== 12'd0 || count !== 3'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL areset_immediate got=v%0b acc%0d cnt%0d r%0b exp=v0 acc0 cnt0 r1", out_valid, acc_out, count, in_ready); end
    checks++; if (s_acc_out !== 12'd0 || s_count !== 6'd0) begin failures++; $display("FAIL areset_sat_inst got=acc%0d cnt%0d exp=acc0 cnt0", s_acc_out, s_count); end
    #1 rst_n = 1;
    model_zero();
    drive(1, 9, 1, 0);
    checks++; if (acc_out !== 12'd9 || count !== 3'd1) begin failures++; $display("FAIL areset_restart got=%0d/%0d exp=9/1", acc_out, count); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_clear();
        test_random();
        test_saturation();
        test_async_reset();
      end
      begin
        #200000;
        failures++;
        $display("FAIL timeout exceeded 200000 time units");
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 4x4 array multiplier. Consumes its 8-bit unsigned products through a valid/ready handshake.
- Sums a fixed-length block of BLOCK_LEN products into a saturating accumulator.
- Presents each block sum through a second valid/ready handshake, with a sticky overflow flag.
- Sits between the combinational multiplier and the top-level output mux, which drives uo_out/uio_out.

Parameters:
- PROD_W, 8, width of incoming product (matches multiplier output)
- ACC_W, 12, accumulator/result width
- BLOCK_LEN, 4, number of products summed per result (>=1)
- CNT_W, $clog2(BLOCK_LEN+1), sample counter width (derived, not overridden)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous clear: aborts the block, empties the accumulator
- in_valid  input  1  product is valid this cycle
- in_ready  output  1  block can accept a product this cycle
- product  input  PROD_W  unsigned product from the array multiplier
- out_valid  output  1  acc_out holds a completed block sum
- out_ready  input  1  consumer takes the result this cycle
- acc_out  output  ACC_W  block sum (saturated)
- overflow  output  1  saturation occurred during the presented block
- count  output  CNT_W  products accepted in the current block

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset, asserted asynchronously:
  - state=ACCUM
  - acc_out=0, count=0, overflow=0, out_valid=0
  - in_ready=1 from the first cycle after deassertion
- FSM states: ACCUM, HOLD.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM, on accept (in_valid && in_ready):
  - acc <= sat(acc + zero-extended product), computed at ACC_W+1 bits.
  - If the true sum exceeds 2^ACC_W-1: acc <= 2^ACC_W-1 and overflow <= 1. Overflow is sticky until the block is consumed or cleared.
  - count <= count+1.
  - If this is the BLOCK_LEN-th accept: go to HOLD and count <= BLOCK_LEN.
- ACCUM, no accept: all state holds. in_valid may toggle freely.
- HOLD:
  - acc_out, overflow and count stay stable while out_valid=1 && out_ready=0.
  - Products offered while in HOLD are not accepted (in_ready=0); the upstream must hold them.
  - On out_valid && out_ready: acc<=0, count<=0, overflow<=0, go to ACCUM. in_ready=1 in the next cycle.
  - No accept in the handoff cycle.
- Latency:
  - Result is visible (out_valid=1) on the cycle after the final accept.
  - Minimum block period is BLOCK_LEN+1 cycles with out_ready tied high.
- clear: synchronous, highest priority over accept and output handshake.
  - Next state is ACCUM; acc, count and overflow return to 0.
  - A product presented in the same cycle is discarded.
  - A pending HOLD result is dropped.
- acc_out is a registered output, equal to the accumulator register at all times (a partial sum is visible in ACCUM).
- Only out_valid qualifies acc_out.
- BLOCK_LEN=1: every accept goes straight to HOLD.
- Widths:
  - product is zero-extended to ACC_W+1 bits before the add.
  - No signed arithmetic.
- Reset mid-block or mid-HOLD: all state is lost immediately, with no pending output.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.

Decomposition:
- Shared package prod_acc_pkg holds:
  - state enum (ACCUM, HOLD)
  - localparams PROD_W_DEF=8, ACC_W_DEF=12, BLOCK_LEN_DEF=4
- One sub-module, sat_adder:
  - Parameterised widths, combinational.
  - Inputs: acc, operand. Outputs: sum saturated to ACC_W, ovf.
- Top of block contains the FSM, counter and registers.

Test Plan:
- Basic block:
  - Stimulus: reset, then defaults with out_ready=1. Feed products 15, 30, 225, 100 on consecutive cycles.
  - Response: out_valid=1 one cycle after the 4th accept; acc_out=370, overflow=0, count=4. Back to in_ready=1 next cycle, with acc_out=0.
- Backpressure:
  - Stimulus: complete a block of sum 900 (4x225) with out_ready=0 for 5 cycles, holding in_valid=1 with product=7.
  - Response: in_ready=0 throughout; acc_out stays 900. After out_ready=1, the 7 is accepted on the first ACCUM cycle.
- Gapped input:
  - Stimulus: in_valid pattern 1,0,0,1,0,1,1 carrying 1,x,x,2,x,3,4.
  - Response: count steps 1,1,1,2,2,3,4; result 10.
- Saturation:
  - Stimulus: BLOCK_LEN=32, ACC_W=12; feed 32 products of 225.
  - Response: after the 19th accept, acc_out=4095 and overflow=1 (true sum 4275). Final acc_out=4095, overflow=1. Both clear after the handshake.
- Clear:
  - Stimulus: assert clear in the same cycle as the 3rd product (value 50) of a block. Separately, assert clear while in HOLD.
  - Response: next cycle acc_out=0, count=0, out_valid=0, in_ready=1; the 50 is not counted.
- Async reset:
  - Stimulus: drop rst_n mid-cycle during HOLD, with no clock edge.
  - Response: out_valid=0, acc_out=0 and count=0 immediately. After release, the first product starts a new block.
